// File: rtl/boot_sequencer.sv
// ============================================================================
// Module   : boot_sequencer
// Brief    : Front-panel reset debouncer, sys_reset pulse stretcher and
//            boot-address sequencer feeding the boot-vector injector.
//            Optional macro BOOT_SWITCH_ADDR_EN: jump target taken from the
//            front-panel address switches instead of BOOT_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_sequencer #(
  parameter logic [15:0] RESET_CYCLES    = 16'd16,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] BOOT_ADDR       = 16'hFD00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_reset,
  input  logic [15:0] sw_addr,
  input  logic        boot_valid,
  output logic        sys_reset,
  output logic [7:0]  lo_addr,
  output logic [7:0]  hi_addr,
  output logic        booting,
  output logic [7:0]  boot_count
);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_BOOT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Button path registers
  logic        sync1_q;
  logic        sync2_q;
  logic [15:0] db_cnt_q;
  logic        btn_db_q;

  // Sequencer registers and next-state values
  state_t      state_q, state_d;
  logic [15:0] h_cnt_q, h_cnt_d;
  logic        sys_reset_q, sys_reset_d;
  logic        booting_q, booting_d;
  logic [7:0]  boot_count_q, boot_count_d;
  logic [7:0]  hi_addr_q, lo_addr_q;
  logic        addr_load_d;

  // Jump-target source for the address latch
  logic [15:0] w_addr_src;
`ifdef BOOT_SWITCH_ADDR_EN
  assign w_addr_src = sw_addr;
`else
  logic unused_sw_addr;
  assign unused_sw_addr = ^sw_addr;
  assign w_addr_src     = BOOT_ADDR;
`endif

  // Synchronize the raw button and debounce it into btn_db_q
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= 16'd0;
      btn_db_q <= 1'b0;
    end else begin
      sync1_q <= btn_reset;
      sync2_q <= sync1_q;
      if (sync2_q == btn_db_q) begin
        db_cnt_q <= 16'd0;
      end else if (db_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        btn_db_q <= sync2_q;
        db_cnt_q <= 16'd0;
      end else begin
        db_cnt_q <= db_cnt_q + 16'd1;
      end
    end
  end

  // Sequencer state, registered outputs and address latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_HOLD;
      h_cnt_q      <= 16'd0;
      sys_reset_q  <= 1'b1;
      booting_q    <= 1'b0;
      boot_count_q <= 8'd0;
      hi_addr_q    <= w_addr_src[15:8];
      lo_addr_q    <= w_addr_src[7:0];
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      sys_reset_q  <= sys_reset_d;
      booting_q    <= booting_d;
      boot_count_q <= boot_count_d;
      if (addr_load_d) begin
        hi_addr_q <= w_addr_src[15:8];
        lo_addr_q <= w_addr_src[7:0];
      end
    end
  end

  // Next-state logic; the button always wins over boot completion
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    boot_count_d = boot_count_q;
    addr_load_d  = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (btn_db_q) begin
          h_cnt_d = 16'd0;
        end else if (h_cnt_q == RESET_CYCLES - 16'd1) begin
          state_d = S_BOOT;
        end else begin
          h_cnt_d = h_cnt_q + 16'd1;
        end
      end
      S_BOOT: begin
        if (btn_db_q) begin
          state_d     = S_HOLD;
          h_cnt_d     = 16'd0;
          addr_load_d = 1'b1;
        end else if (!boot_valid) begin
          state_d = S_RUN;
          if (boot_count_q != 8'hFF) begin
            boot_count_d = boot_count_q + 8'd1;
          end
        end
      end
      S_RUN: begin
        if (btn_db_q) begin
          state_d     = S_HOLD;
          h_cnt_d     = 16'd0;
          addr_load_d = 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        h_cnt_d = 16'd0;
      end
    endcase
    sys_reset_d = (state_d == S_HOLD);
    booting_d   = (state_d == S_BOOT);
  end

  assign sys_reset  = sys_reset_q;
  assign booting    = booting_q;
  assign boot_count = boot_count_q;
  assign hi_addr    = hi_addr_q;
  assign lo_addr    = lo_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_sequencer.sv
// ============================================================================
// Module   : tb_boot_sequencer
// Brief    : Directed self-checking bench for boot_sequencer
//            (RESET_CYCLES=4, DEBOUNCE_CYCLES=3, BOOT_ADDR=16'hFD00).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_sequencer;

  logic        clk;
  logic        reset;
  logic        btn_reset;
  logic [15:0] sw_addr;
  logic        boot_valid;
  logic        sys_reset;
  logic [7:0]  lo_addr;
  logic [7:0]  hi_addr;
  logic        booting;
  logic [7:0]  boot_count;

  int n_checks;
  int n_fail;
  int boots;

`ifdef BOOT_SWITCH_ADDR_EN
  localparam logic [7:0] EXP_HI_SW = 8'h08;
`else
  localparam logic [7:0] EXP_HI_SW = 8'hFD;
`endif

  boot_sequencer #(
    .RESET_CYCLES   (16'd4),
    .DEBOUNCE_CYCLES(16'd3),
    .BOOT_ADDR      (16'hFD00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_reset (btn_reset),
    .sw_addr   (sw_addr),
    .boot_valid(boot_valid),
    .sys_reset (sys_reset),
    .lo_addr   (lo_addr),
    .hi_addr   (hi_addr),
    .booting   (booting),
    .boot_count(boot_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the button 10 cycles then release; the block lands in BOOT
  // exactly 9 edges after the release (5 to debounce release, 4 of HOLD).
  task automatic press_release();
    btn_reset = 1'b1;
    repeat (10) tick();
    btn_reset = 1'b0;
    repeat (9) tick();
  endtask

  // Complete one boot from BOOT
  task automatic finish_boot();
    boot_valid = 1'b0;
    tick();
    boot_valid = 1'b1;
    boots++;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    boots      = 0;
    reset      = 1'b1;
    btn_reset  = 1'b0;
    sw_addr    = 16'h0000;
    boot_valid = 1'b1;

    // Power-on reset values
    repeat (2) tick();
    check("rst_sys_reset", {15'd0, sys_reset}, 16'd1);
    check("rst_booting", {15'd0, booting}, 16'd0);
    check("rst_boot_count", {8'd0, boot_count}, 16'd0);
    check("rst_hi_addr", {8'd0, hi_addr}, 16'h00FD);
    check("rst_lo_addr", {8'd0, lo_addr}, 16'h0000);

    // Reset pulse is exactly 4 edges after release
    reset = 1'b0;
    repeat (3) tick();
    check("por_sys_reset_e3", {15'd0, sys_reset}, 16'd1);
    tick();
    check("por_sys_reset_e4", {15'd0, sys_reset}, 16'd0);
    check("por_booting_e4", {15'd0, booting}, 16'd1);

    // BOOT has no timeout while the injector stays valid
    repeat (20) tick();
    check("boot_hold_booting", {15'd0, booting}, 16'd1);
    check("boot_hold_count", {8'd0, boot_count}, 16'd0);

    // Boot completion
    finish_boot();
    check("done_booting", {15'd0, booting}, 16'd0);
    check("done_sys_reset", {15'd0, sys_reset}, 16'd0);
    check("done_count1", {8'd0, boot_count}, 16'd1);

    // Button press from RUN: sys_reset rises 6 edges after press
    sw_addr   = 16'h0800;
    btn_reset = 1'b1;
    repeat (5) tick();
    check("btn_sys_reset_e5", {15'd0, sys_reset}, 16'd0);
    tick();
    check("btn_sys_reset_e6", {15'd0, sys_reset}, 16'd1);
    check("btn_booting_e6", {15'd0, booting}, 16'd0);
    check("btn_hi_addr", {8'd0, hi_addr}, {8'd0, EXP_HI_SW});
    check("btn_lo_addr", {8'd0, lo_addr}, 16'h0000);
    repeat (4) tick();
    btn_reset = 1'b0;
    sw_addr   = 16'h1234;
    repeat (8) tick();
    check("rel_sys_reset_e8", {15'd0, sys_reset}, 16'd1);
    tick();
    check("rel_sys_reset_e9", {15'd0, sys_reset}, 16'd0);
    check("rel_booting_e9", {15'd0, booting}, 16'd1);
    repeat (5) tick();
    check("boot_hi_stable", {8'd0, hi_addr}, {8'd0, EXP_HI_SW});
    check("boot_lo_stable", {8'd0, lo_addr}, 16'h0000);
    finish_boot();
    check("done_count2", {8'd0, boot_count}, 16'd2);
    check("run_hi_stable", {8'd0, hi_addr}, {8'd0, EXP_HI_SW});
    sw_addr = 16'h0000;

    // Glitch rejection: 2-cycle pulse, then 1/0/1/0 toggling
    btn_reset = 1'b1;
    repeat (2) tick();
    btn_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_pulse", {15'd0, sys_reset}, 16'd0);
    end
    for (int i = 0; i < 8; i++) begin
      btn_reset = ~btn_reset;
      tick();
      check("glitch_toggle", {15'd0, sys_reset}, 16'd0);
    end
    btn_reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_settle", {15'd0, sys_reset}, 16'd0);
    end
    check("glitch_count", {8'd0, boot_count}, 16'd2);

    // Get back to BOOT, then collide btn_db rise with boot_valid fall
    press_release();
    check("sim_pre_booting", {15'd0, booting}, 16'd1);
    btn_reset = 1'b1;
    repeat (5) tick();
    check("sim_pre_edge_booting", {15'd0, booting}, 16'd1);
    boot_valid = 1'b0;
    tick();
    boot_valid = 1'b1;
    check("sim_sys_reset", {15'd0, sys_reset}, 16'd1);
    check("sim_booting", {15'd0, booting}, 16'd0);
    check("sim_count", {8'd0, boot_count}, 16'd2);
    repeat (4) tick();
    btn_reset = 1'b0;
    repeat (9) tick();
    check("sim_back_booting", {15'd0, booting}, 16'd1);

    // Saturation: drive the total number of boots to 300
    boots = 2;
    finish_boot();
    check("sat_count3", {8'd0, boot_count}, 16'd3);
    while (boots < 300) begin
      press_release();
      finish_boot();
    end
    check("sat_count255", {8'd0, boot_count}, 16'd255);
    check("sat_booting", {15'd0, booting}, 16'd0);
    check("sat_hi_addr", {8'd0, hi_addr}, 16'h00FD);

    // Reset mid-operation restores reset values
    reset = 1'b1;
    tick();
    check("mid_rst_sys_reset", {15'd0, sys_reset}, 16'd1);
    check("mid_rst_booting", {15'd0, booting}, 16'd0);
    check("mid_rst_count", {8'd0, boot_count}, 16'd0);
    reset = 1'b0;
    repeat (4) tick();
    check("mid_rst_reboot", {15'd0, booting}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
